sm_cpu_eval: RTL and testbench



---
 rtl/sm_cpu_eval.sv | 76 +++++++
 tb/tb_sm_cpu_eval.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sm_cpu_eval.sv
// sm_cpu_eval: start/done evaluator of y = x>=0 ? 3x+8 : x>>>1 (16b signed x_in -> 32b signed y_out), optional busy output when SM_BUSY_EN is defined
module sm_cpu_eval (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] x_in,
  output logic signed [31:0] y_out,
  output logic               done
`ifdef SM_BUSY_EN
  ,
  output logic               busy
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, DBL, ADDX, ADD8, HALF, DONE} state_t;
  state_t             state_q, state_d;
  logic signed [15:0] x_q, x_d;
  logic signed [31:0] acc_q, acc_d, y_q, y_d, x_ext;
  logic               done_q, done_d;
  assign x_ext = {{16{x_q[15]}}, x_q};
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    y_d     = y_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        x_d     = start ? x_in : x_q;
        state_d = start ? LOAD : IDLE;
      end
      LOAD: state_d = x_q[15] ? HALF : DBL;
      DBL: begin
        acc_d   = x_ext <<< 1;
        state_d = ADDX;
      end
      ADDX: begin
        acc_d   = acc_q + x_ext;
        state_d = ADD8;
      end
      ADD8: begin
        y_d     = acc_q + 32'sd8;
        done_d  = 1'b1;
        state_d = DONE;
      end
      HALF: begin
        y_d     = x_ext >>> 1;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end
  assign y_out = y_q;
  assign done  = done_q;
`ifdef SM_BUSY_EN
  logic busy_q;
  always_ff @(posedge clk) busy_q <= rst ? 1'b0 : (state_d != IDLE);
  assign busy = busy_q;
`endif
endmodule

// File: tb/tb_sm_cpu_eval.sv
// tb_sm_cpu_eval: directed-vector self-checking bench for sm_cpu_eval
module tb_sm_cpu_eval;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] x_in = '0;
  logic signed [31:0] y_out;
  logic               done;
  int                 total = 0;
  int                 bad = 0;
`ifdef SM_BUSY_EN
  logic busy;
`endif
  sm_cpu_eval dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .x_in (x_in),
    .y_out(y_out),
    .done (done)
`ifdef SM_BUSY_EN
    ,
    .busy (busy)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, $signed(got), $signed(exp));
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic signed [15:0] x, input int lat, input logic signed [31:0] exp);
    int bc;
    start = 1'b1;
    x_in  = x;
    step();
    start = 1'b0;
    x_in  = 16'sh5a5a;
    bc = 0;
`ifdef SM_BUSY_EN
    bc += int'(busy);
`endif
    for (int k = 1; k <= lat; k++) begin
      step();
`ifdef SM_BUSY_EN
      bc += int'(busy);
`endif
      if (k < lat) chk("early_done", {31'd0, done}, 32'd0);
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("y", y_out, exp);
    step();
    chk("done_fall", {31'd0, done}, 32'd0);
    chk("y_hold", y_out, exp);
`ifdef SM_BUSY_EN
    chk("busy_cycles", bc, lat + 1);
    chk("busy_off", {31'd0, busy}, 32'd0);
`endif
  endtask
  initial begin
    int dc;
    step();
    step();
    chk("rst_y", y_out, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
`ifdef SM_BUSY_EN
    chk("rst_busy", {31'd0, busy}, 32'd0);
`endif
    rst = 1'b0;
    step();
    run(16'sd10, 4, 32'sd38);
    step();
    chk("y_hold_idle", y_out, 32'sd38);
    run(-16'sd8, 2, -32'sd4);
    run(16'sd0, 4, 32'sd8);
    run(-16'sd1, 2, -32'sd1);
    run(16'sd32767, 4, 32'sd98309);
    run(-16'sh8000, 2, -32'sd16384);
    start = 1'b1;
    x_in  = 16'sd5;
    step();
    dc = 0;
    for (int k = 1; k <= 5; k++) begin
      x_in = (k % 2 == 1) ? 16'sd1000 : -16'sd3;
      step();
      dc += int'(done);
      if (k == 4) chk("held_y", y_out, 32'sd23);
    end
    start = 1'b0;
    chk("held_one_done", dc, 1);
    dc = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      dc += int'(done);
    end
    chk("held_no_extra", dc, 0);
    chk("held_y_keep", y_out, 32'sd23);
    start = 1'b1;
    x_in  = 16'sd7;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_y", y_out, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
`ifdef SM_BUSY_EN
    chk("abort_busy", {31'd0, busy}, 32'd0);
`endif
    dc = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      dc += int'(done);
    end
    chk("abort_no_done", dc, 0);
    rst   = 1'b1;
    start = 1'b1;
    x_in  = 16'sd9;
    step();
    rst   = 1'b0;
    start = 1'b0;
    dc = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      dc += int'(done);
    end
    chk("rst_beats_start", dc, 0);
    run(16'sd1, 4, 32'sd11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
